apple_spawner: RTL

- Consumes the 16-bit one-hot "random" vector from the apple random source and decodes it back to a column index.
- Combines that column with an internal row counter to form a seed cell.
- Probes the snake-body occupancy store cell by cell, in scan order from the seed, until it finds a free cell.
- Publishes the free cell as the new apple position; reports failure when the board is full.

---
 rtl/snake_pkg.sv | 51 +++++
 rtl/onehot_decode16.sv | 18 +
 rtl/apple_spawner.sv | 116 +++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared board geometry, spawner FSM encoding and cell coordinate type for the
// snake game blocks.
package snake_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;
  localparam int XW     = 4;
  localparam int YW     = 4;

  localparam int NUM_CELLS   = GRID_W * GRID_H;
  localparam int PROBE_CNT_W = $clog2(NUM_CELLS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PROBE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } spawn_state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } cell_t;

  // Folds a 0..15 bit index onto the board width so narrow boards still get a
  // legal column from the full 16-bit random vector.
  function automatic logic [XW-1:0] fold_col(input logic [3:0] idx);
    logic [4:0] v;
    v = {1'b0, idx};
    for (int i = 0; i < 16; i++) begin
      if (v >= 5'(GRID_W)) v = v - 5'(GRID_W);
    end
    return v[XW-1:0];
  endfunction

  // Next cell in raster scan order, wrapping from the last cell to (0,0).
  function automatic cell_t next_cell(input cell_t c);
    cell_t n;
    n = c;
    if (c.x == XW'(GRID_W - 1)) begin
      n.x = '0;
      n.y = (c.y == YW'(GRID_H - 1)) ? '0 : c.y + YW'(1);
    end else begin
      n.x = c.x + XW'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/onehot_decode16.sv
// Combinational decode of a 16-bit one-hot vector to the index of its lowest
// set bit; an all-zero vector decodes to 0.
module onehot_decode16 (
  input  logic [15:0] i_onehot,
  output logic [3:0]  o_index
);

  // NOTE: always_comb uses blocking assignments and gives the output a
  // default before the loop, so no latch can be inferred.
  always_comb begin
    o_index = '0;
    // Walking down from the top lets the lowest set bit win.
    for (int i = 15; i >= 0; i--) begin
      if (i_onehot[i]) o_index = 4'(i);
    end
  end

endmodule

// File: rtl/apple_spawner.sv
// Apple placement: turns a random one-hot column plus a free-running row into
// a seed cell, then scans the occupancy store from there for the first free cell.
module apple_spawner
  import snake_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          spawn_req,
  input  logic [15:0]   rand_onehot,
  output logic          probe_valid,
  output logic [XW-1:0] probe_x,
  output logic [YW-1:0] probe_y,
  input  logic          probe_busy,
  output logic          apple_valid,
  output logic [XW-1:0] apple_x,
  output logic [YW-1:0] apple_y,
  output logic          spawn_done,
  output logic          spawn_fail,
  output logic          busy
);

  spawn_state_e           r_state;
  spawn_state_e           w_state_next;
  logic [YW-1:0]          r_row_ctr;
  cell_t                  r_cur;
  cell_t                  r_apple;
  logic                   r_apple_valid;
  logic [PROBE_CNT_W-1:0] r_probe_cnt;

  logic [3:0]             w_index;
  logic [XW-1:0]          w_seed_col;
  logic                   w_accept;
  logic                   w_found;

  onehot_decode16 u_decode (
    .i_onehot (rand_onehot),
    .o_index  (w_index)
  );

  assign w_seed_col = fold_col(w_index);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_found      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spawn_req) begin
          w_accept     = 1'b1;
          w_state_next = ST_PROBE;
        end
      end
      ST_PROBE:   w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (!probe_busy) begin
          w_found      = 1'b1;
          w_state_next = ST_DONE;
        end else if (r_probe_cnt == PROBE_CNT_W'(NUM_CELLS)) begin
          w_state_next = ST_FAIL;
        end else begin
          w_state_next = ST_ADVANCE;
        end
      end
      ST_ADVANCE: w_state_next = ST_PROBE;
      ST_DONE:    w_state_next = ST_IDLE;
      ST_FAIL:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_row_ctr     <= '0;
      r_cur         <= '0;
      r_apple       <= '0;
      r_apple_valid <= 1'b0;
      r_probe_cnt   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_row_ctr <= (r_row_ctr == YW'(GRID_H - 1)) ? '0 : r_row_ctr + YW'(1);

      if (w_accept) begin
        r_cur.x       <= w_seed_col;
        r_cur.y       <= r_row_ctr;
        r_apple_valid <= 1'b0;
        r_probe_cnt   <= '0;
      end

      if (r_state == ST_PROBE)   r_probe_cnt <= r_probe_cnt + PROBE_CNT_W'(1);
      if (r_state == ST_ADVANCE) r_cur       <= next_cell(r_cur);

      if (w_found) begin
        r_apple       <= r_cur;
        r_apple_valid <= 1'b1;
      end
    end
  end

  // Probe coordinates are forced to 0 outside the strobe so the bus is quiet.
  assign probe_valid = (r_state == ST_PROBE);
  assign probe_x     = probe_valid ? r_cur.x : '0;
  assign probe_y     = probe_valid ? r_cur.y : '0;

  assign apple_valid = r_apple_valid;
  assign apple_x     = r_apple.x;
  assign apple_y     = r_apple.y;

  assign spawn_done  = (r_state == ST_DONE);
  assign spawn_fail  = (r_state == ST_FAIL);
  assign busy        = (r_state == ST_PROBE) || (r_state == ST_WAIT) ||
                       (r_state == ST_ADVANCE);

endmodule
